// File: rtl/ex_muldiv_sequencer.sv
// RV32M multiply/divide sequencer for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module ex_muldiv_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_in,
  input  logic        flush_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] ReadData1_in,
  input  logic [31:0] ReadData2_in,
  input  logic [4:0]  Rd_in,
  output logic        stall_out,
  output logic        done_out,
  output logic        busy_out,
  output logic [31:0] result_out,
  output logic [4:0]  Rd_out
);

  typedef enum logic [2:0] {
    IDLE, PREP, CALC, FIX, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, m_q;
  logic [4:0]  rd_q, rdo_q;
  logic        sa_q, sb_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [32:0] rem_q;
  logic [31:0] res_q;

  logic        is_div, div0, ovf;
  logic        sgn_a, sgn_b;
  logic [31:0] abs_a, abs_b;
  logic [31:0] fast_res;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] shifted;
  logic [33:0] trial;
  logic        take;
  logic [32:0] rem_next;
  logic [31:0] q_next;
  logic [63:0] prod;
  logic [31:0] quo, remv, fix_res;

  assign is_div = op_q[2];
  assign sgn_a  = a_q[31] & ((op_q == 3'b001) | (op_q == 3'b010)
                | (op_q == 3'b100) | (op_q == 3'b110));
  assign sgn_b  = b_q[31] & ((op_q == 3'b001)
                | (op_q == 3'b100) | (op_q == 3'b110));
  assign abs_a  = sgn_a ? -a_q : a_q;
  assign abs_b  = sgn_b ? -b_q : b_q;

  assign div0 = is_div & (b_q == 32'd0);
  assign ovf  = is_div & ~op_q[0]
              & (a_q == 32'h8000_0000)
              & (b_q == 32'hFFFF_FFFF);

  // op_q[1] distinguishes REM/REMU from DIV/DIVU
  assign fast_res = op_q[1]
                  ? (div0 ? a_q : 32'd0)
                  : (div0 ? 32'hFFFF_FFFF : 32'h8000_0000);

  assign mul_sum  = {1'b0, acc_q[63:32]}
                  + (acc_q[0] ? {1'b0, m_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  assign shifted  = {rem_q[31:0], acc_q[31]};
  assign trial    = {1'b0, shifted} - {2'b00, m_q};
  assign take     = ~trial[33];
  assign rem_next = take ? trial[32:0] : shifted;
  assign q_next   = {acc_q[30:0], take};

  assign prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo  = (sa_q ^ sb_q) ? -acc_q[31:0] : acc_q[31:0];
  assign remv = sa_q ? -rem_q[31:0] : rem_q[31:0];

  always_comb begin
    fix_res = prod[31:0];
    case (op_q)
      3'b000:  fix_res = prod[31:0];
      3'b001,
      3'b010,
      3'b011:  fix_res = prod[63:32];
      3'b100,
      3'b101:  fix_res = quo;
      default: fix_res = remv;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (flush_in) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_in) state_d = PREP;
        PREP:    state_d = (div0 | ovf) ? DONE : CALC;
        CALC:    if (cnt_q == 5'd31) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign stall_out = rst_n & ~flush_in
                   & (((state_q == IDLE) & start_in)
                   | (state_q == PREP)
                   | (state_q == CALC)
                   | (state_q == FIX));
  assign done_out   = (state_q == DONE) & ~flush_in;
  assign busy_out   = (state_q != IDLE);
  assign result_out = res_q;
  assign Rd_out     = rdo_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      rd_q    <= '0;
      rdo_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_in && !flush_in) begin
            op_q <= funct3_in;
            a_q  <= ReadData1_in;
            b_q  <= ReadData2_in;
            rd_q <= Rd_in;
          end
        end
        PREP: begin
          sa_q  <= sgn_a;
          sb_q  <= sgn_b;
          cnt_q <= '0;
          rem_q <= '0;
          m_q   <= is_div ? abs_b : abs_a;
          acc_q <= {32'd0, is_div ? abs_a : abs_b};
          if (!flush_in && (div0 || ovf)) begin
            res_q <= fast_res;
            rdo_q <= rd_q;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 5'd1;
          acc_q <= is_div ? {32'd0, q_next} : mul_next;
          rem_q <= is_div ? rem_next : rem_q;
        end
        FIX: begin
          if (!flush_in) begin
            res_q <= fix_res;
            rdo_q <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Scoreboard bench for ex_muldiv_sequencer.
// Directed RV32M vectors; a monitor pops expectations on done_out.
module tb_ex_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_in = 1'b0;
  logic        flush_in = 1'b0;
  logic [2:0]  funct3_in = 3'd0;
  logic [31:0] ReadData1_in = 32'd0;
  logic [31:0] ReadData2_in = 32'd0;
  logic [4:0]  Rd_in = 5'd0;
  logic        stall_out, done_out, busy_out;
  logic [31:0] result_out;
  logic [4:0]  Rd_out;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  ex_muldiv_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_in     (start_in),
    .flush_in     (flush_in),
    .funct3_in    (funct3_in),
    .ReadData1_in (ReadData1_in),
    .ReadData2_in (ReadData2_in),
    .Rd_in        (Rd_in),
    .stall_out    (stall_out),
    .done_out     (done_out),
    .busy_out     (busy_out),
    .result_out   (result_out),
    .Rd_out       (Rd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done_out pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done_out) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result_out, e.res);
        check("rd_out", {27'd0, Rd_out}, {27'd0, e.rd});
        check("latency", cyc - acc_cyc, e.lat);
      end
    end
  end

  task automatic issue(input logic [2:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    start_in = 1'b1;
    funct3_in = f;
    ReadData1_in = a;
    ReadData2_in = b;
    Rd_in = rd;
    #1 check("accept_stall", {31'd0, stall_out}, 32'd1);
    @(posedge clk);
    #1;
    start_in = 1'b0;
    funct3_in = ~f;
    ReadData1_in = 32'hDEAD_BEEF;
    ReadData2_in = 32'h1234_5678;
    Rd_in = ~rd;
    acc_cyc = cyc;
  endtask

  task automatic run_op(input logic [2:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] rd,
                        input logic [31:0] exp,
                        input int lat);
    exp_t e;
    int bad;
    bit got;
    e.res = exp;
    e.rd = rd;
    e.lat = lat;
    sb.push_back(e);
    issue(f, a, b, rd);
    bad = 0;
    got = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (stall_out !== ((cyc - acc_cyc) < lat)) bad++;
      if (done_out) begin
        got = 1;
        break;
      end
    end
    check("stall_window", bad, 0);
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    @(negedge clk);
    check("idle_after_done", {31'd0, busy_out}, 32'd0);
    check("result_hold", result_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_done", {31'd0, done_out}, 32'd0);
    check("rst_result", result_out, 32'd0);
    check("rst_rd", {27'd0, Rd_out}, 32'd0);
    rst_n = 1'b1;

    run_op(3'b000, 32'd3, 32'd4, 5'd5, 32'd12, 34);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'd0, 34);
    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'd1, 34);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,
           32'hFFFF_FFFE, 34);
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFF, 34);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,
           32'h4000_0000, 34);
    run_op(3'b101, 32'd13, 32'd0, 5'd7, 32'hFFFF_FFFF, 1);
    run_op(3'b111, 32'd13, 32'd0, 5'd8, 32'd13, 1);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,
           32'h8000_0000, 1);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, 1);
    run_op(3'b100, 32'h8000_0000, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFF, 34);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFD, 34);
    run_op(3'b101, 32'd100, 32'd7, 5'd14, 32'd14, 34);
    run_op(3'b111, 32'd100, 32'd7, 5'd15, 32'd2, 34);

    // Flush a DIV at cycle 10; no result may appear.
    issue(3'b100, 32'd100, 32'd7, 5'd20);
    repeat (10) @(negedge clk);
    flush_in = 1'b1;
    #1 check("flush_stall", {31'd0, stall_out}, 32'd0);
    check("flush_done", {31'd0, done_out}, 32'd0);
    @(posedge clk);
    #1 flush_in = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, busy_out}, 32'd0);
    check("flush_result", result_out, 32'd2);
    run_op(3'b000, 32'd5, 32'd6, 5'd21, 32'd30, 34);

    // Reset mid-CALC of MULHU with start_in held high.
    issue(3'b011, 32'hFFFF_FFFF, 32'd2, 5'd22);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    start_in = 1'b1;
    funct3_in = 3'b000;
    #1 check("rst_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_busy", {31'd0, busy_out}, 32'd0);
    check("rst_mid_done", {31'd0, done_out}, 32'd0);
    check("rst_mid_result", result_out, 32'd0);
    check("rst_mid_rd", {27'd0, Rd_out}, 32'd0);
    @(negedge clk);
    check("rst_hold_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk);
    #1 check("rst_no_accept", {31'd0, busy_out}, 32'd0);
    @(negedge clk);
    start_in = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {31'd0, busy_out}, 32'd0);
    run_op(3'b000, 32'd7, 32'd6, 5'd23, 32'd42, 34);

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
